// File: rtl/l1_icache_assoc.sv
// Set-associative, virtually indexed / physically tagged L1 instruction cache.
// Two-process FSM (IDLE/LOOKUP/MMU_WAIT/L2_WAIT/FLUSH) around per-set valid/tag/data
// storage with lowest-invalid-then-round-robin victim selection and a prefetch fill port.
module l1_icache_assoc #(
    parameter int NUM_SETS   = 8,
    parameter int NUM_WAYS   = 2,
    parameter int LINE_BYTES = 32,
    parameter int PAGE_BITS  = 12,
    parameter int TAG_W      = 32 - PAGE_BITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             addr,
    input  logic                    read_en,
    input  logic                    flush,
    output logic                    busy,
    output logic [31:0]             data_out,
    output logic                    resp_valid,
    output logic                    hit,
    output logic                    miss,
    output logic [31:0]             tlb_query_vaddr,
    output logic                    tlb_query_valid,
    input  logic [31:0]             tlb_paddr,
    input  logic                    tlb_hit,
    output logic [31:0]             mmu_addr,
    output logic                    mmu_request,
    input  logic [31:0]             mmu_paddr,
    input  logic                    mmu_done,
    output logic [31:0]             l2_addr,
    output logic                    l2_request,
    input  logic [LINE_BYTES*8-1:0] l2_data,
    input  logic                    l2_done,
    input  logic [31:0]             prefetch_addr,
    input  logic [LINE_BYTES*8-1:0] prefetch_data,
    input  logic                    prefetch_valid,
    output logic                    prefetch_dropped
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int WORD_W = OFF_W - 2;
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MMU_WAIT,
        L2_WAIT,
        FLUSH
    } state_e;

    // Control and response registers
    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        mmu_addr_q, mmu_addr_d;
    logic               mmu_req_q, mmu_req_d;
    logic [31:0]        l2_addr_q, l2_addr_d;
    logic               l2_req_q, l2_req_d;
    logic [31:0]        data_out_q, data_out_d;
    logic               resp_valid_q, resp_valid_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               pf_drop_q, pf_drop_d;
    logic               flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;

    // Cache storage
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [WAY_W-1:0]    ptr_q   [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];

    // Request decode
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic [TAG_W-1:0]  tlb_tag;
    logic [IDX_W-1:0]  pf_idx;
    logic [TAG_W-1:0]  pf_tag;

    assign req_idx  = addr_q[OFF_W +: IDX_W];
    assign req_word = addr_q[2 +: WORD_W];
    assign tlb_tag  = tlb_paddr[PAGE_BITS +: TAG_W];
    assign pf_idx   = prefetch_addr[OFF_W +: IDX_W];
    assign pf_tag   = prefetch_addr[PAGE_BITS +: TAG_W];

    // Lowest invalid way wins; a full set falls back to its round-robin pointer
    function automatic logic [WAY_W-1:0] pickVictim(input logic [NUM_WAYS-1:0] vld,
                                                    input logic [WAY_W-1:0]    ptr);
        logic [WAY_W-1:0] v;
        logic             found;
        v     = ptr;
        found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !vld[w]) begin
                v     = WAY_W'(w);
                found = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [WAY_W-1:0] nextPtr(input logic [WAY_W-1:0] ptr);
        return (ptr == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr + WAY_W'(1);
    endfunction

    // Tag compare for the demand lookup against the translated physical tag
    logic              lk_hit;
    logic [WAY_W-1:0]  lk_way;
    logic [LINE_W-1:0] lk_line;
    logic [31:0]       lk_word;
    logic [31:0]       fill_word;

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!lk_hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == tlb_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
        lk_line = data_q[req_idx][lk_way];
    end

    assign lk_word   = lk_line[{req_word, 5'b0} +: 32];
    assign fill_word = l2_data[{req_word, 5'b0} +: 32];

    // Prefetch dedup: is the offered tag already resident in its set
    logic pf_present;

    always_comb begin
        pf_present = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[pf_idx][w] && (tag_q[pf_idx][w] == pf_tag)) begin
                pf_present = 1'b1;
            end
        end
    end

    // Single write port: demand fill has priority, prefetch only when nothing else touches storage
    logic              fill_demand;
    logic              pf_write;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_set;
    logic [WAY_W-1:0]  wr_way;
    logic [TAG_W-1:0]  wr_tag;
    logic [LINE_W-1:0] wr_data;

    assign fill_demand = (state_q == L2_WAIT) && l2_done;
    assign pf_write    = prefetch_valid && !pf_present && !fill_demand && (state_q != FLUSH);
    assign pf_drop_d   = prefetch_valid && !pf_write;

    always_comb begin
        wr_en   = 1'b0;
        wr_set  = req_idx;
        wr_way  = pickVictim(valid_q[req_idx], ptr_q[req_idx]);
        wr_tag  = l2_addr_q[PAGE_BITS +: TAG_W];
        wr_data = l2_data;
        if (fill_demand) begin
            wr_en = 1'b1;
        end else if (pf_write) begin
            wr_en   = 1'b1;
            wr_set  = pf_idx;
            wr_way  = pickVictim(valid_q[pf_idx], ptr_q[pf_idx]);
            wr_tag  = pf_tag;
            wr_data = prefetch_data;
        end
    end

    // Next-state and request/response logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mmu_addr_d   = mmu_addr_q;
        mmu_req_d    = mmu_req_q;
        l2_addr_d    = l2_addr_q;
        l2_req_d     = l2_req_q;
        data_out_d   = data_out_q;
        resp_valid_d = 1'b0;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        flush_idx_d  = flush_idx_q;
        // A flush arriving mid-flush is redundant since nothing can be filled during FLUSH
        flush_pend_d = flush_pend_q || (flush && (state_q != IDLE) && (state_q != FLUSH));

        case (state_q)
            IDLE: begin
                if (flush_pend_q || flush) begin
                    state_d      = FLUSH;
                    flush_pend_d = 1'b0;
                    flush_idx_d  = '0;
                end else if (read_en) begin
                    addr_d  = addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (tlb_hit && lk_hit) begin
                    data_out_d   = lk_word;
                    resp_valid_d = 1'b1;
                    hit_d        = 1'b1;
                    state_d      = IDLE;
                end else if (tlb_hit) begin
                    miss_d    = 1'b1;
                    l2_addr_d = {tlb_paddr[31:OFF_W], {OFF_W{1'b0}}};
                    l2_req_d  = 1'b1;
                    state_d   = L2_WAIT;
                end else begin
                    miss_d     = 1'b1;
                    mmu_addr_d = addr_q;
                    mmu_req_d  = 1'b1;
                    state_d    = MMU_WAIT;
                end
            end
            MMU_WAIT: begin
                if (mmu_done) begin
                    mmu_req_d = 1'b0;
                    l2_addr_d = {mmu_paddr[31:OFF_W], {OFF_W{1'b0}}};
                    l2_req_d  = 1'b1;
                    state_d   = L2_WAIT;
                end
            end
            L2_WAIT: begin
                if (l2_done) begin
                    l2_req_d     = 1'b0;
                    data_out_d   = fill_word;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            FLUSH: begin
                flush_idx_d = flush_idx_q + IDX_W'(1);
                if (flush_idx_q == IDX_W'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset forces every output low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            mmu_addr_q   <= '0;
            mmu_req_q    <= 1'b0;
            l2_addr_q    <= '0;
            l2_req_q     <= 1'b0;
            data_out_q   <= '0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            pf_drop_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mmu_addr_q   <= mmu_addr_d;
            mmu_req_q    <= mmu_req_d;
            l2_addr_q    <= l2_addr_d;
            l2_req_q     <= l2_req_d;
            data_out_q   <= data_out_d;
            resp_valid_q <= resp_valid_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            pf_drop_q    <= pf_drop_d;
            flush_pend_q <= flush_pend_d;
            flush_idx_q  <= flush_idx_d;
        end
    end

    // Valid bits and victim pointers: flush clears one set per cycle, fills set valid and advance the pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (state_q == FLUSH) begin
            valid_q[flush_idx_q] <= '0;
            ptr_q[flush_idx_q]   <= '0;
        end else if (wr_en) begin
            valid_q[wr_set][wr_way] <= 1'b1;
            ptr_q[wr_set]           <= nextPtr(ptr_q[wr_set]);
        end
    end

    // Tag and line arrays need no reset because valid bits gate every use
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_set][wr_way]  <= wr_tag;
            data_q[wr_set][wr_way] <= wr_data;
        end
    end

    assign busy             = (state_q != IDLE);
    assign tlb_query_valid  = (state_q == LOOKUP);
    assign tlb_query_vaddr  = addr_q;
    assign mmu_addr         = mmu_addr_q;
    assign mmu_request      = mmu_req_q;
    assign l2_addr          = l2_addr_q;
    assign l2_request       = l2_req_q;
    assign data_out         = data_out_q;
    assign resp_valid       = resp_valid_q;
    assign hit              = hit_q;
    assign miss             = miss_q;
    assign prefetch_dropped = pf_drop_q;

    // Offset bits of translated addresses and untagged prefetch bits carry no information here
    logic unused_bits;
    assign unused_bits = ^{tlb_paddr[OFF_W-1:0], mmu_paddr[OFF_W-1:0], prefetch_addr};

endmodule

// File: tb/tb_l1_icache_assoc.sv
// Directed, table-driven bench for l1_icache_assoc with default parameters
// (8 sets, 2 ways, 32-byte lines, 4 KiB pages): index = addr[7:5], word = addr[4:2].
module tb_l1_icache_assoc;

    localparam int LINE_W = 256;

    logic              clk;
    logic              reset_n;
    logic [31:0]       addr;
    logic              read_en;
    logic              flush;
    logic              busy;
    logic [31:0]       data_out;
    logic              resp_valid;
    logic              hit;
    logic              miss;
    logic [31:0]       tlb_query_vaddr;
    logic              tlb_query_valid;
    logic [31:0]       tlb_paddr;
    logic              tlb_hit;
    logic [31:0]       mmu_addr;
    logic              mmu_request;
    logic [31:0]       mmu_paddr;
    logic              mmu_done;
    logic [31:0]       l2_addr;
    logic              l2_request;
    logic [LINE_W-1:0] l2_data;
    logic              l2_done;
    logic [31:0]       prefetch_addr;
    logic [LINE_W-1:0] prefetch_data;
    logic              prefetch_valid;
    logic              prefetch_dropped;

    int checks = 0;
    int errors = 0;

    // One read transaction with the environment's responses and the values it must produce
    typedef struct {
        logic [31:0] addr;
        logic        tlbHit;
        logic [31:0] tlbPaddr;
        logic [31:0] mmuPaddr;
        logic        expHit;
        logic [31:0] expL2Addr;
        logic [31:0] seed;
        logic [31:0] expData;
        logic        pfOnDone;
        logic [31:0] pfAddr;
        logic        flushInWait;
    } vec_t;

    vec_t vecs [10];
    vec_t v;

    l1_icache_assoc dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .addr             (addr),
        .read_en          (read_en),
        .flush            (flush),
        .busy             (busy),
        .data_out         (data_out),
        .resp_valid       (resp_valid),
        .hit              (hit),
        .miss             (miss),
        .tlb_query_vaddr  (tlb_query_vaddr),
        .tlb_query_valid  (tlb_query_valid),
        .tlb_paddr        (tlb_paddr),
        .tlb_hit          (tlb_hit),
        .mmu_addr         (mmu_addr),
        .mmu_request      (mmu_request),
        .mmu_paddr        (mmu_paddr),
        .mmu_done         (mmu_done),
        .l2_addr          (l2_addr),
        .l2_request       (l2_request),
        .l2_data          (l2_data),
        .l2_done          (l2_done),
        .prefetch_addr    (prefetch_addr),
        .prefetch_data    (prefetch_data),
        .prefetch_valid   (prefetch_valid),
        .prefetch_dropped (prefetch_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Line whose word i holds seed + i
    function automatic logic [LINE_W-1:0] makeLine(input logic [31:0] seed);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) begin
            l[32*i +: 32] = seed + 32'(i);
        end
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_data_out"}, data_out, 0);
        checkOutput({tag, "_resp_valid"}, resp_valid, 0);
        checkOutput({tag, "_hit"}, hit, 0);
        checkOutput({tag, "_miss"}, miss, 0);
        checkOutput({tag, "_tlb_vaddr"}, tlb_query_vaddr, 0);
        checkOutput({tag, "_tlb_valid"}, tlb_query_valid, 0);
        checkOutput({tag, "_mmu_addr"}, mmu_addr, 0);
        checkOutput({tag, "_mmu_req"}, mmu_request, 0);
        checkOutput({tag, "_l2_addr"}, l2_addr, 0);
        checkOutput({tag, "_l2_req"}, l2_request, 0);
        checkOutput({tag, "_pf_dropped"}, prefetch_dropped, 0);
    endtask

    // Runs one read from the current negedge; inputs change and outputs are sampled on negedges
    task automatic applyStimulus(input vec_t t, input string tag);
        addr    = t.addr;
        read_en = 1'b1;
        @(negedge clk);
        read_en        = 1'b0;
        prefetch_valid = 1'b0;
        checkOutput({tag, "_busy_lookup"}, busy, 1);
        checkOutput({tag, "_tlb_valid"}, tlb_query_valid, 1);
        checkOutput({tag, "_tlb_vaddr"}, tlb_query_vaddr, t.addr);
        checkOutput({tag, "_pf_drop_idle"}, prefetch_dropped, 0);
        tlb_hit   = t.tlbHit;
        tlb_paddr = t.tlbPaddr;
        @(negedge clk);
        tlb_hit   = 1'b0;
        tlb_paddr = '0;
        if (t.expHit) begin
            checkOutput({tag, "_resp_valid"}, resp_valid, 1);
            checkOutput({tag, "_hit"}, hit, 1);
            checkOutput({tag, "_miss"}, miss, 0);
            checkOutput({tag, "_data"}, data_out, t.expData);
            checkOutput({tag, "_busy_resp"}, busy, 0);
            checkOutput({tag, "_l2_req_none"}, l2_request, 0);
        end else begin
            checkOutput({tag, "_miss"}, miss, 1);
            checkOutput({tag, "_resp_early"}, resp_valid, 0);
            if (!t.tlbHit) begin
                checkOutput({tag, "_mmu_req"}, mmu_request, 1);
                checkOutput({tag, "_mmu_addr"}, mmu_addr, t.addr);
                checkOutput({tag, "_l2_req_early"}, l2_request, 0);
                @(negedge clk);
                checkOutput({tag, "_mmu_req_held"}, mmu_request, 1);
                mmu_paddr = t.mmuPaddr;
                mmu_done  = 1'b1;
                @(negedge clk);
                mmu_done = 1'b0;
                checkOutput({tag, "_mmu_req_drop"}, mmu_request, 0);
            end else begin
                checkOutput({tag, "_mmu_req_none"}, mmu_request, 0);
            end
            checkOutput({tag, "_l2_req"}, l2_request, 1);
            checkOutput({tag, "_l2_addr"}, l2_addr, t.expL2Addr);
            if (t.flushInWait) flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            checkOutput({tag, "_l2_req_held"}, l2_request, 1);
            checkOutput({tag, "_miss_width"}, miss, 0);
            l2_data = makeLine(t.seed);
            l2_done = 1'b1;
            if (t.pfOnDone) begin
                prefetch_addr  = t.pfAddr;
                prefetch_data  = makeLine(t.seed ^ 32'hFFFF_0000);
                prefetch_valid = 1'b1;
            end
            @(negedge clk);
            l2_done        = 1'b0;
            prefetch_valid = 1'b0;
            checkOutput({tag, "_l2_req_drop"}, l2_request, 0);
            checkOutput({tag, "_resp_valid"}, resp_valid, 1);
            checkOutput({tag, "_hit"}, hit, 0);
            checkOutput({tag, "_data"}, data_out, t.expData);
            checkOutput({tag, "_busy_resp"}, busy, 0);
            if (t.pfOnDone) checkOutput({tag, "_pf_dropped"}, prefetch_dropped, 1);
        end
        @(negedge clk);
        checkOutput({tag, "_resp_width"}, resp_valid, 0);
        checkOutput({tag, "_hit_width"}, hit, 0);
        checkOutput({tag, "_busy_after"}, busy, t.flushInWait);
    endtask

    initial begin
        // Vectors: cold miss, hits, MMU path, VIPT alias hit, replacement in set 2
        vecs[0] = '{32'h0000_1044, 1'b1, 32'h0000_5040, 32'h0, 1'b0, 32'h0000_5040, 32'h1000, 32'h1001, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{32'h0000_1044, 1'b1, 32'h0000_5040, 32'h0, 1'b1, 32'h0, 32'h0, 32'h1001, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{32'h0000_1048, 1'b1, 32'h0000_5040, 32'h0, 1'b1, 32'h0, 32'h0, 32'h1002, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{32'h0000_2020, 1'b0, 32'h0, 32'h0007_3020, 1'b0, 32'h0007_3020, 32'h2000, 32'h2000, 1'b0, 32'h0, 1'b0};
        vecs[4] = '{32'h0000_9024, 1'b1, 32'h0007_3020, 32'h0, 1'b1, 32'h0, 32'h0, 32'h2001, 1'b0, 32'h0, 1'b0};
        vecs[5] = '{32'h0000_3050, 1'b1, 32'h0000_6040, 32'h0, 1'b0, 32'h0000_6040, 32'h3000, 32'h3004, 1'b0, 32'h0, 1'b0};
        vecs[6] = '{32'h0000_405C, 1'b1, 32'h0000_7040, 32'h0, 1'b0, 32'h0000_7040, 32'h4000, 32'h4007, 1'b0, 32'h0, 1'b0};
        vecs[7] = '{32'h0000_3050, 1'b1, 32'h0000_6040, 32'h0, 1'b1, 32'h0, 32'h0, 32'h3004, 1'b0, 32'h0, 1'b0};
        vecs[8] = '{32'h0000_1044, 1'b1, 32'h0000_5040, 32'h0, 1'b0, 32'h0000_5040, 32'h5000, 32'h5001, 1'b0, 32'h0, 1'b0};
        vecs[9] = '{32'h0000_405C, 1'b1, 32'h0000_7040, 32'h0, 1'b1, 32'h0, 32'h0, 32'h4007, 1'b0, 32'h0, 1'b0};

        reset_n        = 1'b0;
        addr           = '0;
        read_en        = 1'b0;
        flush          = 1'b0;
        tlb_paddr      = '0;
        tlb_hit        = 1'b0;
        mmu_paddr      = '0;
        mmu_done       = 1'b0;
        l2_data        = '0;
        l2_done        = 1'b0;
        prefetch_addr  = '0;
        prefetch_data  = '0;
        prefetch_valid = 1'b0;
        #3;
        checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Prefetch of a resident line is dropped and leaves contents alone
        prefetch_addr  = 32'h0007_3020;
        prefetch_data  = makeLine(32'hBAD0);
        prefetch_valid = 1'b1;
        @(negedge clk);
        prefetch_valid = 1'b0;
        checkOutput("pf_resident_dropped", prefetch_dropped, 1);
        @(negedge clk);
        checkOutput("pf_resident_width", prefetch_dropped, 0);
        v = '{32'h0000_9024, 1'b1, 32'h0007_3020, 32'h0, 1'b1, 32'h0, 32'h0, 32'h2001, 1'b0, 32'h0, 1'b0};
        applyStimulus(v, "pf_res_hit");

        // New prefetch offered with the read request is visible to the following lookup
        prefetch_addr  = 32'h0000_8060;
        prefetch_data  = makeLine(32'h6000);
        prefetch_valid = 1'b1;
        v = '{32'h0000_0068, 1'b1, 32'h0000_8060, 32'h0, 1'b1, 32'h0, 32'h0, 32'h6002, 1'b0, 32'h0, 1'b0};
        applyStimulus(v, "pf_new_hit");

        // Prefetch colliding with a demand fill: demand written, prefetch dropped
        v = '{32'h0000_00A8, 1'b1, 32'h0009_A0A0, 32'h0, 1'b0, 32'h0009_A0A0, 32'h7000, 32'h7002, 1'b1, 32'h0000_C0C0, 1'b0};
        applyStimulus(v, "pf_vs_demand");
        v = '{32'h0000_00C0, 1'b1, 32'h0000_C0C0, 32'h0, 1'b0, 32'h0000_C0C0, 32'hE000, 32'hE000, 1'b0, 32'h0, 1'b0};
        applyStimulus(v, "pf_lost_miss");
        v = '{32'h0000_00A8, 1'b1, 32'h0009_A0A0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h7002, 1'b0, 32'h0, 1'b0};
        applyStimulus(v, "demand_kept");

        // Flush raised during L2_WAIT: response first, then exactly 8 busy cycles
        v = '{32'h0000_01E4, 1'b1, 32'h000A_B1E0, 32'h0, 1'b0, 32'h000A_B1E0, 32'h8000, 32'h8001, 1'b0, 32'h0, 1'b1};
        applyStimulus(v, "flush_wait");
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("flush_busy%0d", i), busy, 1);
        end
        @(negedge clk);
        checkOutput("flush_busy_end", busy, 0);
        v = '{32'h0000_01E4, 1'b1, 32'h000A_B1E0, 32'h0, 1'b0, 32'h000A_B1E0, 32'h8100, 32'h8101, 1'b0, 32'h0, 1'b0};
        applyStimulus(v, "post_flush_a");
        v = '{32'h0000_9024, 1'b1, 32'h0007_3020, 32'h0, 1'b0, 32'h0007_3020, 32'h2100, 32'h2101, 1'b0, 32'h0, 1'b0};
        applyStimulus(v, "post_flush_b");

        // Reset asserted during MMU_WAIT clears outputs without waiting for a clock
        addr    = 32'h0000_2020;
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        tlb_hit = 1'b0;
        @(negedge clk);
        checkOutput("rst_mmu_req_before", mmu_request, 1);
        #2 reset_n = 1'b0;
        #1 checkAllZero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        mmu_paddr = 32'h0005_5000;
        mmu_done  = 1'b1;
        @(negedge clk);
        mmu_done = 1'b0;
        checkOutput("stray_mmu_busy", busy, 0);
        checkOutput("stray_mmu_l2_req", l2_request, 0);
        checkOutput("stray_mmu_l2_addr", l2_addr, 0);
        v = '{32'h0000_2020, 1'b1, 32'h0007_3020, 32'h0, 1'b0, 32'h0007_3020, 32'h2200, 32'h2200, 1'b0, 32'h0, 1'b0};
        applyStimulus(v, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
